mem_access_ctrl: RTL and testbench

//  Dual-issue memory-stage controller directly upstream of data_memory. Accepts one bundle of two

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_slot_decode.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared op encodings, default memory depth and the byte-to-word index helper
// used by the memory-stage controller and its per-slot decoders.
package mem_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int unsigned DEPTH_DEFAULT = 1000;

  // Word index of a byte address: drop the two byte-offset bits, zero-extend.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/mem_slot_decode.sv
// Per-slot decode: classifies the op, flags misaligned or out-of-range
// accesses and produces the data_memory word index for one issue slot.
module mem_slot_decode
  import mem_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  output logic          is_load,
  output logic          is_store,
  output logic          fault,
  output logic [31:0]   idx
);

  logic [31:0] addr32_s;
  logic        mem_op_s;
  logic        misalign_s;
  logic        out_of_range_s;

  // Decode op class, word index and legality; reserved ops behave as none.
  always_comb begin
    addr32_s = 32'(addr);
    idx      = word_index(addr32_s);
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
    mem_op_s       = is_load | is_store;
    misalign_s     = (addr[1:0] != 2'b00);
    out_of_range_s = (idx >= 32'(DEPTH));
    fault          = mem_op_s & (misalign_s | out_of_range_s);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Dual-issue memory-stage controller: drives data_memory strobes for an
// accepted bundle, resolves same-word hazards between the two slots and
// presents load results one cycle later under a valid/ready handshake.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          In_valid,
  output logic          In_ready,
  input  logic [1:0]    Op1,
  input  logic [1:0]    Op2,
  input  logic [AW-1:0] Addr1,
  input  logic [AW-1:0] Addr2,
  input  logic [DW-1:0] Wdata1,
  input  logic [DW-1:0] Wdata2,
  output logic          Out_valid,
  input  logic          Out_ready,
  output logic          Ld1_valid,
  output logic          Ld2_valid,
  output logic [DW-1:0] Ld1_data,
  output logic [DW-1:0] Ld2_data,
  output logic          Fault1,
  output logic          Fault2,
  output logic          RE1,
  output logic          RE2,
  output logic          WE1,
  output logic          WE2,
  output logic [31:0]   A1,
  output logic [31:0]   A2,
  output logic [DW-1:0] WD1,
  output logic [DW-1:0] WD2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2
);

  logic          is_load1_s, is_store1_s, fault1_s;
  logic          is_load2_s, is_store2_s, fault2_s;
  logic [31:0]   idx1_s, idx2_s;
  logic          accept_s;
  logic          ld1_ok_s, st1_ok_s, ld2_ok_s, st2_ok_s;
  logic          same_word_s;
  logic          fwd_hit_s;

  logic          out_valid_r;
  logic          ld1_valid_r, ld2_valid_r;
  logic          fault1_r, fault2_r;
  logic          fwd_hit_r;
  logic [DW-1:0] fwd_r;

  mem_slot_decode #(.AW(AW), .DEPTH(DEPTH)) u_dec1 (
    .op       (Op1),
    .addr     (Addr1),
    .is_load  (is_load1_s),
    .is_store (is_store1_s),
    .fault    (fault1_s),
    .idx      (idx1_s)
  );

  mem_slot_decode #(.AW(AW), .DEPTH(DEPTH)) u_dec2 (
    .op       (Op2),
    .addr     (Addr2),
    .is_load  (is_load2_s),
    .is_store (is_store2_s),
    .fault    (fault2_s),
    .idx      (idx2_s)
  );

  assign In_ready = Rst_n & (~out_valid_r | Out_ready);
  assign accept_s = In_valid & In_ready;

  // Hazard resolution and strobe gating; faulting slots never touch memory.
  always_comb begin
    ld1_ok_s    = is_load1_s  & ~fault1_s;
    st1_ok_s    = is_store1_s & ~fault1_s;
    ld2_ok_s    = is_load2_s  & ~fault2_s;
    st2_ok_s    = is_store2_s & ~fault2_s;
    same_word_s = (idx1_s == idx2_s);
    // Younger load of a word the older slot stores: memory would return stale data.
    fwd_hit_s   = st1_ok_s & ld2_ok_s & same_word_s;
    RE1 = accept_s & ld1_ok_s;
    RE2 = accept_s & ld2_ok_s & ~fwd_hit_s;
    // Two stores to one word: only the younger one is written.
    WE1 = accept_s & st1_ok_s & ~(st2_ok_s & same_word_s);
    WE2 = accept_s & st2_ok_s;
  end

  assign A1  = idx1_s;
  assign A2  = idx2_s;
  assign WD1 = Wdata1;
  assign WD2 = Wdata2;

  // Result register: handshake state plus per-slot flags captured on accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_r <= 1'b0;
      ld1_valid_r <= 1'b0;
      ld2_valid_r <= 1'b0;
      fault1_r    <= 1'b0;
      fault2_r    <= 1'b0;
      fwd_hit_r   <= 1'b0;
      fwd_r       <= {DW{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      ld1_valid_r <= ld1_ok_s;
      ld2_valid_r <= ld2_ok_s;
      fault1_r    <= fault1_s;
      fault2_r    <= fault2_s;
      fwd_hit_r   <= fwd_hit_s;
      if (fwd_hit_s) begin
        fwd_r <= Wdata1;
      end else begin
        fwd_r <= fwd_r;
      end
    end else if (Out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign Out_valid = out_valid_r;
  assign Ld1_valid = ld1_valid_r;
  assign Ld2_valid = ld2_valid_r;
  assign Fault1    = fault1_r;
  assign Fault2    = fault2_r;

  // Load data muxing: forwarded store data overrides stale RD2; invalid slots read 0.
  always_comb begin
    if (ld1_valid_r) begin
      Ld1_data = RD1;
    end else begin
      Ld1_data = {DW{1'b0}};
    end
    if (!ld2_valid_r) begin
      Ld2_data = {DW{1'b0}};
    end else if (fwd_hit_r) begin
      Ld2_data = fwd_r;
    end else begin
      Ld2_data = RD2;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural data_memory
// (read-before-write, read data registered one cycle after RE).
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_valid, In_ready;
  logic [1:0]  Op1, Op2;
  logic [31:0] Addr1, Addr2, Wdata1, Wdata2;
  logic        Out_valid, Out_ready;
  logic        Ld1_valid, Ld2_valid;
  logic [31:0] Ld1_data, Ld2_data;
  logic        Fault1, Fault2;
  logic        RE1, RE2, WE1, WE2;
  logic [31:0] A1, A2, WD1, WD2;
  logic [31:0] RD1, RD2;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:999];

  always #5 Clk = ~Clk;

  mem_access_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready),
    .Op1(Op1), .Op2(Op2), .Addr1(Addr1), .Addr2(Addr2),
    .Wdata1(Wdata1), .Wdata2(Wdata2), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Ld1_valid(Ld1_valid), .Ld2_valid(Ld2_valid), .Ld1_data(Ld1_data), .Ld2_data(Ld2_data),
    .Fault1(Fault1), .Fault2(Fault2), .RE1(RE1), .RE2(RE2), .WE1(WE1), .WE2(WE2),
    .A1(A1), .A2(A2), .WD1(WD1), .WD2(WD2), .RD1(RD1), .RD2(RD2)
  );

  // data_memory model: reads sample old contents, writes land at the same edge
  always @(posedge Clk) begin
    if (RE1 && A1 < 32'd1000) RD1 <= mem[A1];
    if (RE2 && A2 < 32'd1000) RD2 <= mem[A2];
    if (WE1 && A1 < 32'd1000) mem[A1] <= WD1;
    if (WE2 && A2 < 32'd1000) mem[A2] <= WD2;
  end

  task automatic drive(input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] d2);
    @(negedge Clk);
    In_valid = 1'b1;
    Op1 = o1; Addr1 = a1; Wdata1 = d1;
    Op2 = o2; Addr2 = a2; Wdata2 = d2;
    #1;
  endtask

  task automatic idle();
    @(negedge Clk);
    In_valid = 1'b0; Op1 = 2'b00; Op2 = 2'b00; Out_ready = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Out_ready = 1'b1;
    In_valid = 1'b1; Op1 = 2'b01; Addr1 = 32'h10; Op2 = 2'b10; Addr2 = 32'h14;
    Wdata1 = 32'h0; Wdata2 = 32'h0;
    #1;
    checks++; if (In_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", In_ready); end
    checks++; if ({RE1, RE2, WE1, WE2} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {RE1, RE2, WE1, WE2}); end
    checks++; if ({Out_valid, Ld1_valid, Ld2_valid, Fault1, Fault2} !== 5'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=00000", {Out_valid, Ld1_valid, Ld2_valid, Fault1, Fault2}); end
    @(negedge Clk);
    Rst_n = 1'b1; In_valid = 1'b0;
    #1;
    checks++; if (In_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", In_ready); end
    // accept a bundle, stall it, then reset mid-flight
    drive(2'b01, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0);
    Out_ready = 1'b0;
    @(posedge Clk); #1;
    checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_inflight got=%b exp=1", Out_valid); end
    #1 Rst_n = 1'b0;
    #1;
    checks++; if ({Out_valid, Ld1_valid, In_ready} !== 3'b000) begin failures++; $display("FAIL reset_midflight got=%b exp=000", {Out_valid, Ld1_valid, In_ready}); end
    checks++; if (RE1 !== 1'b0) begin failures++; $display("FAIL reset_midflight_re got=%b exp=0", RE1); end
    @(negedge Clk);
    Rst_n = 1'b1; In_valid = 1'b0; Out_ready = 1'b1;
    #1;
    checks++; if (In_ready !== 1'b1) begin failures++; $display("FAIL reset_release2 got=%b exp=1", In_ready); end
  endtask

  task automatic test_store_then_load();
    idle();
    drive(2'b10, 32'h10, 32'hAAAA5555, 2'b00, 32'h0, 32'h0);
    checks++; if ({WE1, RE1, A1} !== {1'b1, 1'b0, 32'd4}) begin failures++; $display("FAIL st_strobe got=%b%b A1=%0d exp=10 A1=4", WE1, RE1, A1); end
    @(posedge Clk); #1;
    drive(2'b00, 32'h0, 32'h0, 2'b01, 32'h10, 32'h0);
    checks++; if ({RE2, A2} !== {1'b1, 32'd4}) begin failures++; $display("FAIL ld2_strobe got=%b A2=%0d exp=1 A2=4", RE2, A2); end
    @(posedge Clk); #1;
    checks++; if ({Out_valid, Ld2_valid, Ld1_valid} !== 3'b110) begin failures++; $display("FAIL ld2_flags got=%b exp=110", {Out_valid, Ld2_valid, Ld1_valid}); end
    checks++; if (Ld2_data !== 32'hAAAA5555) begin failures++; $display("FAIL ld2_data got=%h exp=aaaa5555", Ld2_data); end
    checks++; if (Ld1_data !== 32'h0) begin failures++; $display("FAIL ld1_masked got=%h exp=0", Ld1_data); end
  endtask

  task automatic test_forward();
    drive(2'b10, 32'h20, 32'h1111, 2'b01, 32'h20, 32'h0);
    checks++; if ({WE1, RE2} !== 2'b10) begin failures++; $display("FAIL fwd_strobe got=%b exp=10", {WE1, RE2}); end
    @(posedge Clk); #1;
    checks++; if ({Ld2_valid, Ld2_data} !== {1'b1, 32'h1111}) begin failures++; $display("FAIL fwd_data got=%b %h exp=1 00001111", Ld2_valid, Ld2_data); end
  endtask

  task automatic test_store_store_and_war();
    drive(2'b10, 32'h30, 32'd1, 2'b10, 32'h30, 32'd2);
    checks++; if ({WE1, WE2} !== 2'b01) begin failures++; $display("FAIL ss_strobe got=%b exp=01", {WE1, WE2}); end
    @(posedge Clk); #1;
    drive(2'b01, 32'h30, 32'h0, 2'b00, 32'h0, 32'h0);
    @(posedge Clk); #1;
    checks++; if (Ld1_data !== 32'd2) begin failures++; $display("FAIL ss_result got=%h exp=2", Ld1_data); end
    drive(2'b01, 32'h10, 32'h0, 2'b10, 32'h10, 32'h5A5A);
    checks++; if ({RE1, WE2} !== 2'b11) begin failures++; $display("FAIL ls_strobe got=%b exp=11", {RE1, WE2}); end
    @(posedge Clk); #1;
    checks++; if (Ld1_data !== 32'hAAAA5555) begin failures++; $display("FAIL ls_old_value got=%h exp=aaaa5555", Ld1_data); end
    drive(2'b00, 32'h0, 32'h0, 2'b01, 32'h10, 32'h0);
    @(posedge Clk); #1;
    checks++; if (Ld2_data !== 32'h5A5A) begin failures++; $display("FAIL ls_new_value got=%h exp=5a5a", Ld2_data); end
  endtask

  task automatic test_fault();
    drive(2'b01, 32'h3, 32'h0, 2'b01, 32'd4000, 32'h0);
    checks++; if ({RE1, RE2, WE1, WE2} !== 4'b0000) begin failures++; $display("FAIL fault_strobes got=%b exp=0000", {RE1, RE2, WE1, WE2}); end
    @(posedge Clk); #1;
    checks++; if ({Out_valid, Fault1, Fault2, Ld1_valid, Ld2_valid} !== 5'b11100) begin failures++; $display("FAIL fault_flags got=%b exp=11100", {Out_valid, Fault1, Fault2, Ld1_valid, Ld2_valid}); end
    checks++; if ({Ld1_data, Ld2_data} !== 64'h0) begin failures++; $display("FAIL fault_data got=%h %h exp=0 0", Ld1_data, Ld2_data); end
    // index 999 is the last legal word
    drive(2'b10, 32'd3996, 32'hCAFE0001, 2'b00, 32'h0, 32'h0);
    checks++; if ({WE1, A1} !== {1'b1, 32'd999}) begin failures++; $display("FAIL edge_store got=%b A1=%0d exp=1 A1=999", WE1, A1); end
    @(posedge Clk); #1;
    drive(2'b01, 32'd3996, 32'h0, 2'b10, 32'h6, 32'h77);
    checks++; if ({RE1, WE2} !== 2'b10) begin failures++; $display("FAIL edge_strobes got=%b exp=10", {RE1, WE2}); end
    @(posedge Clk); #1;
    checks++; if ({Fault1, Fault2, Ld1_valid, Ld1_data} !== {3'b011, 32'hCAFE0001}) begin failures++; $display("FAIL edge_result got=%b%b%b %h exp=011 cafe0001", Fault1, Fault2, Ld1_valid, Ld1_data); end
  endtask

  task automatic test_empty_bundle();
    drive(2'b11, 32'h1, 32'h0, 2'b00, 32'h3, 32'h0);
    checks++; if ({RE1, RE2, WE1, WE2} !== 4'b0000) begin failures++; $display("FAIL empty_strobes got=%b exp=0000", {RE1, RE2, WE1, WE2}); end
    @(posedge Clk); #1;
    checks++; if ({Out_valid, Fault1, Fault2, Ld1_valid, Ld2_valid} !== 5'b10000) begin failures++; $display("FAIL empty_flags got=%b exp=10000", {Out_valid, Fault1, Fault2, Ld1_valid, Ld2_valid}); end
  endtask

  task automatic test_back_to_back();
    idle();
    Out_ready = 1'b0;
    drive(2'b01, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0);
    @(posedge Clk); #1;
    checks++; if ({Out_valid, Ld1_data} !== {1'b1, 32'h5A5A}) begin failures++; $display("FAIL bp_first got=%b %h exp=1 00005a5a", Out_valid, Ld1_data); end
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 32'h20, 32'h0, 2'b00, 32'h0, 32'h0);
      checks++; if ({In_ready, RE1} !== 2'b00) begin failures++; $display("FAIL bp_stall_%0d got=%b exp=00", i, {In_ready, RE1}); end
      @(posedge Clk); #1;
      checks++; if ({Out_valid, Ld1_data} !== {1'b1, 32'h5A5A}) begin failures++; $display("FAIL bp_hold_%0d got=%b %h exp=1 00005a5a", i, Out_valid, Ld1_data); end
    end
    @(negedge Clk);
    Out_ready = 1'b1;
    #1;
    checks++; if ({In_ready, RE1} !== 2'b11) begin failures++; $display("FAIL bp_release got=%b exp=11", {In_ready, RE1}); end
    @(posedge Clk); #1;
    checks++; if ({Out_valid, Ld1_data} !== {1'b1, 32'h1111}) begin failures++; $display("FAIL bp_b2b got=%b %h exp=1 00001111", Out_valid, Ld1_data); end
    idle();
    checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", Out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 1000; i++) mem[i] = 32'h0;
    RD1 = 32'h0; RD2 = 32'h0;
    test_reset();
    test_store_then_load();
    test_forward();
    test_store_store_and_war();
    test_fault();
    test_empty_bundle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
